// File: rtl/control_fsm.sv
// Multi-cycle RV32I sequencer: steps each instruction through FETCH, DECODE, EXEC,
// optional MEM and WB, drives every datapath enable/select and counts retired instructions.
module control_fsm #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic [4:0]             rd,
  input  logic                   bit20,
  input  logic                   branch_taken,
  input  logic                   mem_ready,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_addr_sel,
  output logic                   ir_we,
  output logic                   mdr_we,
  output logic                   rf_we,
  output logic [1:0]             wb_sel,
  output logic [1:0]             alu_a_sel,
  output logic                   alu_b_sel,
  output logic                   alu_fn_sel,
  output logic                   pc_we,
  output logic [1:0]             pc_sel,
  output logic                   halted,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instret
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  state_t                 state, state_next;
  logic                   taken_q;
  logic                   halted_q;
  logic                   illegal_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load;
  logic is_store, is_opimm, is_op, is_misc, supported, is_halt_op;
  logic [1:0] cls_a_sel;
  logic       cls_b_sel;
  logic       cls_fn_sel;

  // ECALL and EBREAK halt identically, so inst[20] carries no information here.
  logic unused_bits;
  assign unused_bits = bit20;

  always_comb begin
    is_lui     = (opcode == OPC_LUI);
    is_auipc   = (opcode == OPC_AUIPC);
    is_jal     = (opcode == OPC_JAL);
    is_jalr    = (opcode == OPC_JALR);
    is_branch  = (opcode == OPC_BRANCH);
    is_load    = (opcode == OPC_LOAD);
    is_store   = (opcode == OPC_STORE);
    is_opimm   = (opcode == OPC_OPIMM);
    is_op      = (opcode == OPC_OP);
    is_misc    = (opcode == OPC_MISC);
    supported  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                 is_store | is_opimm | is_op | is_misc;
    is_halt_op = (opcode == OPC_SYSTEM) && (funct3 == 3'd0);
  end

  always_comb begin
    cls_a_sel  = 2'd0;
    cls_b_sel  = 1'b0;
    cls_fn_sel = 1'b0;
    if (is_op) begin
      cls_fn_sel = 1'b1;
    end else if (is_opimm) begin
      cls_b_sel  = 1'b1;
      cls_fn_sel = 1'b1;
    end else if (is_lui) begin
      cls_a_sel = 2'd2;
      cls_b_sel = 1'b1;
    end else if (is_auipc) begin
      cls_a_sel = 2'd1;
      cls_b_sel = 1'b1;
    end else if (is_load | is_store | is_jalr) begin
      cls_b_sel = 1'b1;
    end else if (is_branch) begin
      cls_fn_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      taken_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state <= state_next;
      if (state == EXEC && is_branch) taken_q <= branch_taken;
      if (state == DECODE && !supported) begin
        if (is_halt_op) halted_q <= 1'b1;
        else            illegal_q <= 1'b1;
      end
      if (state == WB) count_q <= count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    alu_fn_sel   = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = supported ? EXEC : HALT;
      EXEC: begin
        alu_a_sel  = cls_a_sel;
        alu_b_sel  = cls_b_sel;
        alu_fn_sel = cls_fn_sel;
        state_next = (is_load | is_store) ? MEM : WB;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        alu_a_sel    = cls_a_sel;
        alu_b_sel    = cls_b_sel;
        alu_fn_sel   = cls_fn_sel;
        if (mem_ready) begin
          mdr_we     = is_load;
          state_next = WB;
        end
      end
      WB: begin
        pc_we  = 1'b1;
        rf_we  = (rd != 5'd0) &&
                 (is_op | is_opimm | is_lui | is_auipc | is_load | is_jal | is_jalr);
        wb_sel = is_load ? 2'd1 : ((is_jal | is_jalr) ? 2'd2 : 2'd0);
        if (is_jal)                    pc_sel = 2'd1;
        else if (is_jalr)              pc_sel = 2'd2;
        else if (is_branch && taken_q) pc_sel = 2'd1;
        if (is_jalr) begin
          alu_a_sel  = cls_a_sel;
          alu_b_sel  = cls_b_sel;
          alu_fn_sel = cls_fn_sel;
        end
        state_next = FETCH;
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
    // Reset parks the FSM in FETCH; keep the memory port and enables quiet until release.
    if (!reset_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      mdr_we  = 1'b0;
      rf_we   = 1'b0;
      pc_we   = 1'b0;
    end
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign instret = count_q;

endmodule
